// File: rtl/if_stage_if.sv
// Fetch-stage bus: hazard/redirect controls, instruction-memory port and the
// decode-facing {pc, inst, valid} triple.
interface if_stage_if #(
    parameter int unsigned PC_WIDTH   = 32,
    parameter int unsigned INST_WIDTH = 32
);
    logic                  stall;
    logic                  redirect;
    logic [PC_WIDTH-1:0]   redirect_pc;
    logic [PC_WIDTH-1:0]   imem_addr;
    logic [INST_WIDTH-1:0] imem_rdata;
    logic [PC_WIDTH-1:0]   pc_out;
    logic [PC_WIDTH-1:0]   pc_plus4_out;
    logic [INST_WIDTH-1:0] inst_out;
    logic                  valid_out;

    modport master (
        input  stall, redirect, redirect_pc, imem_rdata,
        output imem_addr, pc_out, pc_plus4_out, inst_out, valid_out
    );

    modport slave (
        output stall, redirect, redirect_pc, imem_rdata,
        input  imem_addr, pc_out, pc_plus4_out, inst_out, valid_out
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, drives a 1-cycle synchronous
// instruction memory and realigns its read data with the matching PC for decode.
module if_stage #(
    parameter int unsigned           PC_WIDTH   = 32,
    parameter int unsigned           INST_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_PC   = 32'h0000_2000,
    parameter logic [INST_WIDTH-1:0] NOP_INST   = 32'h0000_0013
) (
    input  logic       clk,
    input  logic       rst,
    if_stage_if.master bus
);
    logic [PC_WIDTH-1:0]   pc_f;
    logic [PC_WIDTH-1:0]   pc_d;
    logic                  valid_d;
    logic                  hold_flag;
    logic [INST_WIDTH-1:0] inst_hold;
    logic [INST_WIDTH-1:0] inst_c;

    // During a stall the memory re-reads pc_f, so the data for pc_d must be captured once.
    always_comb begin
        inst_c = bus.imem_rdata;
        if (!valid_d) begin
            inst_c = NOP_INST;
        end else if (hold_flag) begin
            inst_c = inst_hold;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_f      <= RESET_PC;
            pc_d      <= RESET_PC;
            valid_d   <= 1'b0;
            hold_flag <= 1'b0;
            inst_hold <= NOP_INST;
        end else if (bus.redirect) begin
            // Word-align the target; the in-flight wrong-path read becomes a bubble.
            pc_f      <= bus.redirect_pc & ~PC_WIDTH'(3);
            valid_d   <= 1'b0;
            hold_flag <= 1'b0;
        end else if (bus.stall) begin
            if (!hold_flag) begin
                inst_hold <= inst_c;
                hold_flag <= 1'b1;
            end
        end else begin
            pc_d      <= pc_f;
            valid_d   <= 1'b1;
            pc_f      <= pc_f + PC_WIDTH'(4);
            hold_flag <= 1'b0;
        end
    end

    assign bus.imem_addr    = pc_f;
    assign bus.pc_out       = pc_d;
    assign bus.pc_plus4_out = pc_d + PC_WIDTH'(4);
    assign bus.inst_out     = inst_c;
    assign bus.valid_out    = valid_d;
endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios with literal expectations plus a
// randomized run, all checked against a decode-view reference model.
module tb_if_stage;
    localparam logic [31:0] RESET_PC = 32'h0000_2000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    if_stage_if #(.PC_WIDTH(32), .INST_WIDTH(32)) bus ();

    if_stage #(
        .PC_WIDTH(32), .INST_WIDTH(32), .RESET_PC(RESET_PC), .NOP_INST(NOP_INST)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_2000: return 32'hA0A0_0001;
            32'h0000_2004: return 32'hB0B0_0002;
            32'h0000_2008: return 32'hC0C0_0003;
            32'h0000_3000: return 32'h3000_1111;
            default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
        endcase
    endfunction

    // Synchronous-read instruction memory, one cycle latency.
    always @(posedge clk) bus.imem_rdata <= mem_word(bus.imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model of what decode sees: the current slot (valid, pc) and the
    // next PC to be delivered; the instruction is just memory at the slot's PC.
    logic        m_live = 1'b0;
    logic        m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_next;

    always @(posedge clk) begin
        if (rst) begin
            m_live  <= 1'b1;
            m_valid <= 1'b0;
            m_pc    <= RESET_PC;
            m_next  <= RESET_PC;
        end else if (bus.redirect) begin
            m_valid <= 1'b0;
            m_next  <= {bus.redirect_pc[31:2], 2'b00};
        end else if (!bus.stall) begin
            m_valid <= 1'b1;
            m_pc    <= m_next;
            m_next  <= m_next + 32'd4;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("valid_out", 32'(bus.valid_out), 32'(m_valid));
            chk("pc_out", bus.pc_out, m_pc);
            chk("pc_plus4_out", bus.pc_plus4_out, m_pc + 32'd4);
            chk("imem_addr", bus.imem_addr, m_next);
            chk("inst_out", bus.inst_out, m_valid ? mem_word(m_pc) : NOP_INST);
        end
    end

    // Drive inputs just after a falling edge, then return at the next falling edge.
    task automatic step(input logic r, input logic s, input logic d, input logic [31:0] t);
        rst             = r;
        bus.stall       = s;
        bus.redirect    = d;
        bus.redirect_pc = t;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic lit(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] inst);
        chk({tag, "_valid"}, 32'(bus.valid_out), 32'(v));
        chk({tag, "_pc"}, bus.pc_out, pc);
        chk({tag, "_inst"}, bus.inst_out, inst);
    endtask

    logic [31:0] tgt;

    initial begin
        bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
        @(negedge clk);

        // Reset, then free-run through A, B, C with stalls on B.
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        lit("rst", 1'b0, 32'h2000, NOP_INST);
        chk("rst_imem_addr", bus.imem_addr, 32'h2000);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        lit("runA", 1'b1, 32'h2000, 32'hA0A0_0001);
        chk("runA_pc4", bus.pc_plus4_out, 32'h2004);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        lit("runB", 1'b1, 32'h2004, 32'hB0B0_0002);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0);
            lit("stallB", 1'b1, 32'h2004, 32'hB0B0_0002);
            chk("stallB_imem_addr", bus.imem_addr, 32'h2008);
        end
        step(1'b0, 1'b0, 1'b0, 32'h0);
        lit("runC", 1'b1, 32'h2008, 32'hC0C0_0003);
        chk("runC_pc4", bus.pc_plus4_out, 32'h200C);

        // Redirect while B is presented, alone and together with stall.
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 1'b0, 1'b0, 32'h0);
            step(1'b0, 1'b0, 1'b0, 32'h0);
            step(1'b0, 1'b0, 1'b0, 32'h0);
            lit("preB", 1'b1, 32'h2004, 32'hB0B0_0002);
            step(1'b0, k == 1, 1'b1, 32'h3001);
            chk("redir_bubble_valid", 32'(bus.valid_out), 32'd0);
            chk("redir_bubble_inst", bus.inst_out, NOP_INST);
            step(1'b0, 1'b0, 1'b0, 32'h0);
            lit("redir_tgt", 1'b1, 32'h3000, 32'h3000_1111);
        end

        // Reset during a stall clears the hold.
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        lit("rst_stall", 1'b0, 32'h2000, NOP_INST);
        chk("rst_stall_imem_addr", bus.imem_addr, 32'h2000);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        lit("rst_stall_A", 1'b1, 32'h2000, 32'hA0A0_0001);

        // PC wrap at the top of the address space.
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        lit("wrap0", 1'b1, 32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC));
        chk("wrap0_pc4", bus.pc_plus4_out, 32'h0000_0000);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        lit("wrap1", 1'b1, 32'h0000_0000, mem_word(32'h0000_0000));

        // Randomized controls; the model compare process checks every cycle.
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 3))
                0:       tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                1:       tgt = 32'h0000_2000 | 32'($urandom_range(0, 255));
                default: tgt = $urandom;
            endcase
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 11) == 0, tgt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
